// File: rtl/block_stream_sequencer_if.sv
// Handshake wiring around the block sequencer: upstream AXI-stream, datapath and output path.
// The sequencer only gates valid/ready; tdata is routed elsewhere.
interface block_stream_sequencer_if;
    logic s_axis_input_tvalid;
    logic s_axis_input_tready;
    logic s_axis_weights_tvalid;
    logic s_axis_weights_tready;
    logic dp_input_tvalid;
    logic dp_input_tready;
    logic dp_input_last;
    logic dp_weights_tvalid;
    logic dp_weights_tready;
    logic dp_output_tvalid;
    logic dp_output_tready;
    logic m_axis_output_tvalid;
    logic m_axis_output_tready;

    // Valid/ready: a beat transfers on any rising edge where both are 1; a valid, once raised,
    // is not expected to drop before its ready, and the sequencer never holds a beat itself.
    modport master (
        input  s_axis_input_tvalid,
        output s_axis_input_tready,
        input  s_axis_weights_tvalid,
        output s_axis_weights_tready,
        output dp_input_tvalid,
        input  dp_input_tready,
        output dp_input_last,
        output dp_weights_tvalid,
        input  dp_weights_tready,
        input  dp_output_tvalid,
        output dp_output_tready,
        output m_axis_output_tvalid,
        input  m_axis_output_tready
    );

    modport slave (
        output s_axis_input_tvalid,
        input  s_axis_input_tready,
        output s_axis_weights_tvalid,
        input  s_axis_weights_tready,
        input  dp_input_tvalid,
        output dp_input_tready,
        input  dp_input_last,
        input  dp_weights_tvalid,
        output dp_weights_tready,
        output dp_output_tvalid,
        input  dp_output_tready,
        input  m_axis_output_tvalid,
        output m_axis_output_tready
    );
endinterface

// File: rtl/block_stream_sequencer.sv
// Per-block phase sequencer: load weights, stream one block of input, drain its outputs,
// repeated for every block of a stream; all handshakes pass through with zero latency.
module block_stream_sequencer #(
    parameter int BDIM        = 64,
    parameter int SDIM        = 1024,
    parameter int WEIGHT_BDIM = 32,
    parameter int OUT_BDIM    = 16,
    localparam int BMAX_A     = (BDIM > WEIGHT_BDIM) ? BDIM : WEIGHT_BDIM,
    localparam int BMAX       = (BMAX_A > OUT_BDIM) ? BMAX_A : OUT_BDIM,
    localparam int BW         = (BMAX > 0) ? $clog2(BMAX + 1) : 1,
    localparam int NBLK       = SDIM / ((BDIM == 0) ? 1 : BDIM),
    localparam int KW         = (NBLK > 0) ? $clog2(NBLK + 1) : 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    block_stream_sequencer_if.master bus,
    output logic [2:0]              dbg_state_o,
    output logic [BW-1:0]           dbg_beat_cnt_o,
    output logic [KW-1:0]           dbg_blk_cnt_o
);

    if (BDIM <= 0 || SDIM <= 0 || WEIGHT_BDIM <= 0 || OUT_BDIM <= 0) begin : g_bad_zero
        $error("block_stream_sequencer: all dimensions must be non-zero");
    end
    if (BDIM > 0 && (SDIM % ((BDIM == 0) ? 1 : BDIM)) != 0) begin : g_bad_div
        $error("block_stream_sequencer: SDIM must be a multiple of BDIM");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [BW-1:0] W_LAST   = BW'(WEIGHT_BDIM - 1);
    localparam logic [BW-1:0] I_LAST   = BW'(BDIM - 1);
    localparam logic [BW-1:0] O_LAST   = BW'(OUT_BDIM - 1);
    localparam logic [KW-1:0] BLK_LAST = KW'(NBLK - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [KW-1:0] blk_cnt_q, blk_cnt_d;

    logic s_in_ready, s_w_ready, dp_in_valid, dp_in_last, dp_w_valid, dp_out_ready, m_out_valid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        ap_done      = 1'b0;
        ap_idle      = 1'b0;
        s_in_ready   = 1'b0;
        s_w_ready    = 1'b0;
        dp_in_valid  = 1'b0;
        dp_in_last   = 1'b0;
        dp_w_valid   = 1'b0;
        dp_out_ready = 1'b0;
        m_out_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_d    = S_LOAD_W;
                    beat_cnt_d = '0;
                    blk_cnt_d  = '0;
                end
            end
            S_LOAD_W: begin
                dp_w_valid = bus.s_axis_weights_tvalid;
                s_w_ready  = bus.dp_weights_tready;
                if (bus.s_axis_weights_tvalid && bus.dp_weights_tready) begin
                    if (beat_cnt_q == W_LAST) begin
                        state_d    = S_STREAM;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                dp_in_valid = bus.s_axis_input_tvalid;
                s_in_ready  = bus.dp_input_tready;
                dp_in_last  = (beat_cnt_q == I_LAST);
                if (bus.s_axis_input_tvalid && bus.dp_input_tready) begin
                    if (beat_cnt_q == I_LAST) begin
                        state_d    = S_DRAIN;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                m_out_valid  = bus.dp_output_tvalid;
                dp_out_ready = bus.m_axis_output_tready;
                if (bus.dp_output_tvalid && bus.m_axis_output_tready) begin
                    if (beat_cnt_q == O_LAST) begin
                        // Weights are reloaded before every block, so a non-final block loops back.
                        beat_cnt_d = '0;
                        blk_cnt_d  = blk_cnt_q + 1'b1;
                        state_d    = (blk_cnt_q == BLK_LAST) ? S_DONE : S_LOAD_W;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.s_axis_input_tready   = s_in_ready;
    assign bus.s_axis_weights_tready = s_w_ready;
    assign bus.dp_input_tvalid       = dp_in_valid;
    assign bus.dp_input_last         = dp_in_last;
    assign bus.dp_weights_tvalid     = dp_w_valid;
    assign bus.dp_output_tready      = dp_out_ready;
    assign bus.m_axis_output_tvalid  = m_out_valid;

    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = beat_cnt_q;
    assign dbg_blk_cnt_o  = blk_cnt_q;

endmodule

// File: doc/block_stream_sequencer.md
BLOCK_STREAM_SEQUENCER -- requirements
Module: block_stream_sequencer

Interface
REQ-001 The block SHALL have parameter BDIM, default 64: input beats per block.
REQ-002 The block SHALL have parameter SDIM, default 1024: input beats per stream. SDIM is a multiple of BDIM.
REQ-003 The block SHALL have parameter WEIGHT_BDIM, default 32: weight beats loaded before each block.
REQ-004 The block SHALL have parameter OUT_BDIM, default 16: output beats drained after each block.
REQ-005 The block SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-006 The block SHALL have port ap_rst_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have the following control ports:
- ap_start  in  1  starts one stream run.
- ap_done  out  1  one-cycle end-of-run pulse.
- ap_idle  out  1  high in IDLE.
REQ-008 The block SHALL have the following upstream ports:
- s_axis_input_tvalid  in  1
- s_axis_input_tready  out  1
- s_axis_weights_tvalid  in  1
- s_axis_weights_tready  out  1
REQ-009 The block SHALL have the following datapath ports:
- dp_input_tvalid  out  1
- dp_input_tready  in  1
- dp_input_last  out  1  marks the last beat of a block.
- dp_weights_tvalid  out  1
- dp_weights_tready  in  1
REQ-010 The block SHALL have the following output-path ports:
- dp_output_tvalid  in  1
- dp_output_tready  out  1
- m_axis_output_tvalid  out  1
- m_axis_output_tready  in  1
Tdata does not pass through this block.

Function
REQ-011 The block SHALL implement the FSM states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-012 In IDLE, ap_start=1 SHALL move the FSM to LOAD_W on the next edge and clear beat_cnt and blk_cnt. ap_start SHALL be ignored in all other states.
REQ-013 In LOAD_W, the block SHALL pass weights through combinationally:
- dp_weights_tvalid=s_axis_weights_tvalid
- s_axis_weights_tready=dp_weights_tready
REQ-014 In LOAD_W, the block SHALL increment beat_cnt on each weight handshake. The handshake on which beat_cnt reaches WEIGHT_BDIM-1 SHALL move the FSM to STREAM and clear beat_cnt.
REQ-015 In STREAM, the block SHALL pass input through combinationally:
- dp_input_tvalid=s_axis_input_tvalid
- s_axis_input_tready=dp_input_tready
REQ-016 In STREAM, dp_input_last SHALL be 1 only while beat_cnt==BDIM-1. The handshake on that beat SHALL move the FSM to DRAIN and clear beat_cnt.
REQ-017 In DRAIN, the block SHALL pass output through combinationally:
- m_axis_output_tvalid=dp_output_tvalid
- dp_output_tready=m_axis_output_tready
REQ-018 In DRAIN, the handshake on the OUT_BDIM-th output beat SHALL increment blk_cnt. The FSM SHALL then go to DONE if blk_cnt was SDIM/BDIM-1, else to LOAD_W, since weights are reloaded for every block.
REQ-019 In DONE, ap_done SHALL be 1 for exactly one cycle, and the FSM SHALL move to IDLE on the next edge.
REQ-020 In every state, every tvalid/tready output belonging to a non-active phase SHALL be 0 and dp_input_last SHALL be 0 outside STREAM.
REQ-021 The block SHALL add zero cycles of pass-through latency, and a phase transition SHALL take effect on the edge of that phase's final handshake.
REQ-022 The block SHALL size counters as $clog2(max(BDIM,WEIGHT_BDIM,OUT_BDIM)+1) for beat_cnt and $clog2(SDIM/BDIM+1) for blk_cnt, with no wrap inside a run.
REQ-023 The block SHALL NOT change state on a cycle where the active-phase valid is high and ready is low (a stall).
REQ-024 Parameter values that are 0, or SDIM not divisible by BDIM, SHALL raise an elaboration-time error.

Reset
REQ-025 While ap_rst_n=0, the block SHALL immediately hold the FSM in IDLE, beat_cnt=0 and blk_cnt=0, ap_idle=1, and all other outputs 0.
REQ-026 A reset asserted mid-run SHALL abandon the run with no ap_done. After release, the block SHALL wait in IDLE for a new ap_start.

Verification
REQ-027 Configuration BDIM=4, SDIM=8, WEIGHT_BDIM=2, OUT_BDIM=1, with all valids and readies held at 1 and ap_start pulsed at cycle 0, SHALL produce:
- LOAD_W in cycles 1-2, STREAM in cycles 3-6, DRAIN in cycle 7.
- LOAD_W in cycles 8-9, STREAM in cycles 10-13, DRAIN in cycle 14.
- ap_done=1 in cycle 15 only, and ap_idle=1 from cycle 16.
REQ-028 Same configuration, with dp_input_tready=0 for 3 cycles during STREAM beat 2, SHALL show beat_cnt held, dp_input_last still asserted only on beat 3, and ap_done delayed by exactly 3 cycles.
REQ-029 Same configuration, with ap_start pulsed again during STREAM, SHALL give no effect: exactly one ap_done and exactly 8 input handshakes.
REQ-030 Same configuration, with ap_rst_n driven low asynchronously mid-cycle in DRAIN, SHALL show all tready/tvalid outputs at 0 before the next edge, ap_idle=1, no ap_done, and a subsequent ap_start completing a full 15-cycle run.
REQ-031 Same configuration, with s_axis_weights_tvalid=1 during STREAM, SHALL show s_axis_weights_tready=0 and no weight handshake counted.
